// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types and defaults for the serial word link
// transmitter.
//   state_t    : transmitter FSM states (IDLE, SHIFT, GAP)
//   SER_WIDTH  : default word width in bits
//   SER_GAP    : default number of idle cycles forced after each word
package serializer_pkg;

  localparam int SER_WIDTH = 32;
  localparam int SER_GAP   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/serializer_if.sv
// serializer_if: parallel load handshake plus serial link outputs.
//   data_in      : parallel word, sampled when load_valid & load_ready
//   load_valid   : producer offers a word
//   load_ready   : transmitter can take a word (holding buffer empty)
//   serial_out   : serial data bit, LSB first, 0 when not framed
//   serial_valid : frames each word (WIDTH consecutive cycles)
//   busy         : shifting, in the inter-word gap, or buffer occupied
// master = word producer / link observer, slave = serializer.
interface serializer_if
  import serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  busy
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output serial_out,
    output serial_valid,
    output busy
  );

endinterface

// File: rtl/serializer_hold_buf.sv
// serializer_hold_buf: single-entry word buffer with valid/ready on both
// sides. Lets the next word be accepted while the current one shifts.
//   clk, rst_n          : clock, async active-low reset (empties buffer)
//   in_data/in_valid    : word offered for storage
//   in_ready            : buffer empty, a push is accepted this cycle
//   out_data/out_valid  : stored word, valid while full
//   out_ready           : consumer takes the stored word this cycle
// No push and pop on the same edge is possible: a push needs the buffer
// empty, a pop needs it full.
module serializer_hold_buf
  import serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             full;
  logic [WIDTH-1:0] data;

  assign in_ready  = ~full;
  assign out_valid = full;
  assign out_data  = data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_valid && out_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/serializer.sv
// serializer: 32:1 (WIDTH:1) parallel-to-serial transmitter of the serial
// word link. Words arrive over a valid/ready handshake and leave LSB first,
// one bit per clock, framed by serial_valid, followed by GAP_CYCLES idle
// cycles so the receiver can publish each word.
//   clk, rst_n : clock, async active-low reset (drops in-flight words)
//   bus        : serializer_if slave (load handshake + serial outputs)
// A word taken while idle (or exactly as the gap ends with the buffer
// empty) goes straight into the shift register; otherwise it waits in the
// one-entry holding buffer, which also gates load_ready.
module serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = SER_WIDTH,
  parameter int GAP_CYCLES = SER_GAP
) (
  input  logic        clk,
  input  logic        rst_n,
  serializer_if.slave bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_GAP   = GAP;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;

  logic             buf_ready;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_data;

  logic             accept;
  logic             gap_done;
  logic             take_new;
  logic             buf_push;

  // load_ready is purely "buffer empty"; when the word can start at once it
  // bypasses the buffer instead of being pushed into it.
  assign accept   = bus.load_valid & buf_ready;
  assign gap_done = (state == ST_GAP) && (gap_cnt == '0);
  assign take_new = accept & ((state == ST_IDLE) | (gap_done & ~buf_valid));
  assign buf_push = accept & ~take_new;

  serializer_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (bus.data_in),
    .in_valid  (buf_push),
    .in_ready  (buf_ready),
    .out_data  (buf_data),
    .out_valid (buf_valid),
    .out_ready (gap_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_new) begin
            shreg   <= bus.data_in;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg <= shreg >> 1;
          // counter holds at its terminal value; it is re-zeroed on load
          if (bit_cnt == BIT_LAST) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (buf_valid) begin
            // buffered word has priority; load_ready was 0 so no new accept
            shreg   <= buf_data;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end else if (take_new) begin
            shreg   <= bus.data_in;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // serial_valid comes straight from the state register, so an async reset
  // drops it immediately.
  assign bus.load_ready   = buf_ready;
  assign bus.serial_valid = (state == ST_SHIFT);
  assign bus.serial_out   = (state == ST_SHIFT) & shreg[0];
  assign bus.busy         = (state != ST_IDLE) | buf_valid;

endmodule

// File: tb/tb_serializer.sv
module tb_serializer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serializer_if #(.WIDTH(32)) b32 ();
  serializer_if #(.WIDTH(8))  b8 ();

  serializer #(.WIDTH(32), .GAP_CYCLES(1)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32.slave)
  );

  serializer #(.WIDTH(8), .GAP_CYCLES(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  // Model: each accepted word gets a start edge = max(accept edge,
  // previous start + W + G). Outputs after edge t follow from that list.
  logic [31:0] wd [2][16];
  int          ac [2][16];
  int          st [2][16];
  int          nw [2];
  // Receiver view: frames reassembled from the serial line.
  logic [31:0] capw [2][16];
  int          capl [2][16];
  int          gaps [2][16];
  int          ncap [2];
  int          idle [2];
  int          flen [2];
  logic [31:0] cur  [2];
  logic        prev_sv [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int k, input int w, input int g,
                      input logic sv, input logic so, input logic lr,
                      input logic bz, input logic lv, input logic [31:0] din);
    logic esv, eso, elr, ebz;
    int   s;
    if (!rst_n) begin
      nw[k] = 0; ncap[k] = 0; idle[k] = 0; flen[k] = 0;
      cur[k] = '0; prev_sv[k] = 1'b0;
    end
    esv = 1'b0; eso = 1'b0; elr = 1'b1; ebz = 1'b0;
    for (int i = 0; i < nw[k]; i++) begin
      if (cyc >= st[k][i] && cyc < st[k][i] + w) begin
        esv = 1'b1;
        eso = wd[k][i][cyc - st[k][i]];
      end
      if (cyc >= st[k][i] && cyc < st[k][i] + w + g) ebz = 1'b1;
      if (cyc >= ac[k][i] && cyc < st[k][i]) begin
        elr = 1'b0;
        ebz = 1'b1;
      end
    end
    chk($sformatf("w%0d serial_valid", w), sv, esv);
    chk($sformatf("w%0d serial_out", w), so, eso);
    chk($sformatf("w%0d load_ready", w), lr, elr);
    chk($sformatf("w%0d busy", w), bz, ebz);
    if (rst_n) begin
      if (sv) begin
        if (!prev_sv[k]) begin
          if (ncap[k] > 0 && ncap[k] <= 16) gaps[k][ncap[k]-1] = idle[k];
          flen[k] = 0;
          cur[k]  = '0;
        end
        if (flen[k] < 32) cur[k][flen[k]] = so;
        flen[k]++;
      end else begin
        if (prev_sv[k] && ncap[k] < 16) begin
          capw[k][ncap[k]] = cur[k];
          capl[k][ncap[k]] = flen[k];
          ncap[k]++;
          idle[k] = 0;
        end
        idle[k]++;
      end
      prev_sv[k] = sv;
      if (lv && lr && nw[k] < 16) begin
        s = cyc + 1;
        if (nw[k] > 0 && st[k][nw[k]-1] + w + g > s) s = st[k][nw[k]-1] + w + g;
        wd[k][nw[k]] = din;
        ac[k][nw[k]] = cyc + 1;
        st[k][nw[k]] = s;
        nw[k]++;
      end
    end
  endtask

  always @(negedge clk) begin
    step(0, 32, 1, b32.serial_valid, b32.serial_out, b32.load_ready, b32.busy,
         b32.load_valid, b32.data_in);
    step(1, 8, 3, b8.serial_valid, b8.serial_out, b8.load_ready, b8.busy,
         b8.load_valid, {24'd0, b8.data_in});
  end

  // Hold a word on the port until it is taken; n = cycles waited.
  task automatic offer(input int k, input logic [31:0] w, output int n);
    logic acc;
    n = 0;
    acc = 1'b0;
    if (k == 0) begin b32.data_in = w; b32.load_valid = 1'b1; end
    else begin b8.data_in = w[7:0]; b8.load_valid = 1'b1; end
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (k == 0) ? b32.load_ready : b8.load_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("offer accepted", {31'd0, acc}, 32'd1);
    if (k == 0) b32.load_valid = 1'b0;
    else b8.load_valid = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int   n = 0;
    logic bz = 1'b1;
    while (bz && n < 500) begin
      @(negedge clk);
      bz = (k == 0) ? b32.busy : b8.busy;
      n++;
    end
    chk("idle reached", {31'd0, bz}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    int          b;
    logic [31:0] exp2 [3];
    exp2[0] = 32'h0000_0001;
    exp2[1] = 32'h8000_0000;
    exp2[2] = 32'hFFFF_FFFF;
    b32.data_in = '0; b32.load_valid = 1'b0;
    b8.data_in  = '0; b8.load_valid  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst serial_valid", {31'd0, b32.serial_valid}, 32'd0);
    chk("rst serial_out",   {31'd0, b32.serial_out},   32'd0);
    chk("rst load_ready",   {31'd0, b32.load_ready},   32'd1);
    chk("rst busy",         {31'd0, b32.busy},         32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single word: first bit visible right after the accepting edge
    b = ncap[0];
    offer(0, 32'hA5A5_0F01, n);
    chk("t1 latency valid", {31'd0, b32.serial_valid}, 32'd1);
    chk("t1 bit0",          {31'd0, b32.serial_out},   32'd1);
    wait_idle(0);
    chk("t1 frames", ncap[0] - b, 1);
    chk("t1 word",   capw[0][b], 32'hA5A5_0F01);
    chk("t1 len",    capl[0][b], 32);

    // back-to-back with load_valid kept high
    b = ncap[0];
    offer(0, exp2[0], n);
    offer(0, exp2[1], n);
    chk("t2 ready low", {31'd0, b32.load_ready}, 32'd0);
    offer(0, exp2[2], n);
    chk("t2 third wait", n, 33);
    wait_idle(0);
    chk("t2 frames", ncap[0] - b, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2 word", capw[0][b+i], exp2[i]);
      chk("t2 len",  capl[0][b+i], 32);
    end
    chk("t2 gap a", gaps[0][b], 1);
    chk("t2 gap b", gaps[0][b+1], 1);

    // receiver view of two words
    b = ncap[0];
    offer(0, 32'h1234_5678, n);
    offer(0, 32'hDEAD_BEEF, n);
    wait_idle(0);
    chk("t3 word a", capw[0][b],   32'h1234_5678);
    chk("t3 word b", capw[0][b+1], 32'hDEAD_BEEF);
    chk("t3 gap",    gaps[0][b],   1);

    // WIDTH=8, GAP_CYCLES=3
    b = ncap[1];
    offer(1, 32'h3C, n);
    offer(1, 32'hC3, n);
    wait_idle(1);
    chk("t4 word a", capw[1][b],   32'h3C);
    chk("t4 word b", capw[1][b+1], 32'hC3);
    chk("t4 len a",  capl[1][b],   8);
    chk("t4 len b",  capl[1][b+1], 8);
    chk("t4 gap",    gaps[1][b],   3);

    // async reset at bit 15 with a word buffered
    offer(0, 32'hCAFE_F00D, n);
    offer(0, 32'h0BAD_BEEF, n);
    repeat (14) @(posedge clk);
    #3;
    chk("t5 pre valid", {31'd0, b32.serial_valid}, 32'd1);
    chk("t5 pre bit15", {31'd0, b32.serial_out},   32'd1);
    chk("t5 pre ready", {31'd0, b32.load_ready},   32'd0);
    rst_n = 1'b0;
    #1;
    chk("t5 rst valid", {31'd0, b32.serial_valid}, 32'd0);
    chk("t5 rst ready", {31'd0, b32.load_ready},   32'd1);
    chk("t5 rst busy",  {31'd0, b32.busy},         32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    offer(0, 32'h0000_FFFF, n);
    wait_idle(0);
    chk("t5 frames", ncap[0], 1);
    chk("t5 word",   capw[0][0], 32'h0000_FFFF);
    chk("t5 len",    capl[0][0], 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
